// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// reg_bank_arbiter -- round-robin arbiter issuing CLR/LOAD/INCR ops to a bank.
// Optional whole-bank sweep compiled in by defining REG_BANK_ARB_SWEEP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_bank_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [IDX_W*NUM_REQ-1:0]     req_idx,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [2*NUM_REGS-1:0]        reg_ctrl,
  output logic [DATA_WIDTH-1:0]        reg_data,
  input  logic                         sweep_req,
  output logic                         sweep_busy,
  output logic                         idx_err
);

  localparam int         RR_W    = $clog2(NUM_REQ);
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;

  logic [RR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REGS-1:0]  reg_ctrl_q, reg_ctrl_d;
  logic [DATA_WIDTH-1:0]  reg_data_q, reg_data_d;
  logic                   idx_err_q, idx_err_d;

  logic                   arb_en;
  logic                   gnt_found;
  logic [RR_W-1:0]        gnt_idx;
  logic                   transfer;
  logic [1:0]             sel_op;
  logic [IDX_W-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0]  sel_data;

`ifdef REG_BANK_ARB_SWEEP_EN
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SWEEP = 1'b1;
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

  // A sweep request wins over any pending requester in the same cycle.
  assign arb_en     = rst && (state_q == ST_IDLE) && !sweep_req;
  assign sweep_busy = (state_q == ST_SWEEP);

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_req) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
      ST_SWEEP: begin
        if (sweep_cnt_q == LAST_REG) begin
          state_d = ST_IDLE;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end
`else
  logic unused_sweep_req;

  assign unused_sweep_req = sweep_req;
  assign arb_en           = rst;
  assign sweep_busy       = 1'b0;
`endif

  // Search starts at rr_ptr_q and wraps; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = RR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign req_ready = (arb_en && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign transfer  = |(req_valid & req_ready);
  assign sel_op    = req_op[2*int'(gnt_idx) +: 2];
  assign sel_idx   = req_idx[IDX_W*int'(gnt_idx) +: IDX_W];
  assign sel_data  = req_data[DATA_WIDTH*int'(gnt_idx) +: DATA_WIDTH];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    reg_ctrl_d = '0;
    reg_data_d = reg_data_q;
    idx_err_d  = 1'b0;
    if (transfer) begin
      rr_ptr_d = RR_W'((int'(gnt_idx) + 1) % NUM_REQ);
      if (int'(sel_idx) >= NUM_REGS) begin
        idx_err_d = 1'b1;
      end else if (sel_op != OP_NONE) begin
        reg_data_d = sel_data;
        for (int r = 0; r < NUM_REGS; r++) begin
          if (int'(sel_idx) == r) reg_ctrl_d[2*r +: 2] = sel_op;
        end
      end
    end
`ifdef REG_BANK_ARB_SWEEP_EN
    if (state_q == ST_SWEEP) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (int'(sweep_cnt_q) == r) reg_ctrl_d[2*r +: 2] = OP_CLR;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      reg_ctrl_q <= '0;
      reg_data_q <= '0;
      idx_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      reg_ctrl_q <= reg_ctrl_d;
      reg_data_q <= reg_data_d;
      idx_err_q  <= idx_err_d;
    end
  end

  assign reg_ctrl = reg_ctrl_q;
  assign reg_data = reg_data_q;
  assign idx_err  = idx_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// tb_reg_bank_arbiter -- directed scenarios plus randomized traffic checked
// against a behavioural model of the arbiter and bank-control issue.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_bank_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NQ = 4;
  localparam int IW = 3;   // wide enough to present out-of-range indices

`ifdef REG_BANK_ARB_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NQ-1:0]     req_valid;
  logic [2*NQ-1:0]   req_op;
  logic [IW*NQ-1:0]  req_idx;
  logic [DW*NQ-1:0]  req_data;
  logic [NQ-1:0]     req_ready;
  logic [2*NR-1:0]   reg_ctrl;
  logic [DW-1:0]     reg_data;
  logic              sweep_req;
  logic              sweep_busy;
  logic              idx_err;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int          m_rr;
  bit          m_sweep;
  int          m_k;
  int          m_ctrl [NR];
  logic [DW-1:0] m_data;
  bit          m_err;

  reg_bank_arbiter #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_REQ(NQ), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx), .req_data(req_data),
    .req_ready(req_ready), .reg_ctrl(reg_ctrl), .reg_data(reg_data),
    .sweep_req(sweep_req), .sweep_busy(sweep_busy), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int find_grant();
    for (int i = 0; i < NQ; i++) begin
      if (req_valid[(m_rr + i) % NQ]) return (m_rr + i) % NQ;
    end
    return -1;
  endfunction

  function automatic logic [NQ-1:0] exp_ready();
    int g;
    if (!rst || m_sweep || (SWEEP_EN && sweep_req)) return '0;
    g = find_grant();
    if (g < 0) return '0;
    return NQ'(1 << g);
  endfunction

  function automatic logic [2*NR-1:0] ctrl_vec();
    logic [2*NR-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[2*r +: 2] = 2'(m_ctrl[r]);
    return v;
  endfunction

  task automatic m_reset();
    m_rr    = 0;
    m_sweep = 1'b0;
    m_k     = 0;
    m_data  = '0;
    m_err   = 1'b0;
    for (int r = 0; r < NR; r++) m_ctrl[r] = 0;
  endtask

  task automatic m_update();
    int g, op, idx;
    if (!rst) begin
      m_reset();
    end else begin
      for (int r = 0; r < NR; r++) m_ctrl[r] = 0;
      m_err = 1'b0;
      if (m_sweep) begin
        m_ctrl[m_k] = 1;
        m_k++;
        if (m_k == NR) m_sweep = 1'b0;
      end else if (SWEEP_EN && sweep_req) begin
        m_sweep = 1'b1;
        m_k     = 0;
      end else begin
        g = find_grant();
        if (g >= 0) begin
          m_rr = (g + 1) % NQ;
          op   = int'(req_op[2*g +: 2]);
          idx  = int'(req_idx[IW*g +: IW]);
          if (idx >= NR) m_err = 1'b1;
          else if (op != 0) begin
            m_ctrl[idx] = op;
            m_data      = req_data[DW*g +: DW];
          end
        end
      end
    end
  endtask

  // Check at the falling edge, then advance DUT and model together.
  task automatic step();
    @(negedge clk);
    chk("ready",   64'(req_ready),  64'(exp_ready()));
    chk("ctrl",    64'(reg_ctrl),   64'(ctrl_vec()));
    chk("data",    64'(reg_data),   64'(m_data));
    chk("idx_err", 64'(idx_err),    64'(m_err));
    chk("busy",    64'(sweep_busy), 64'(m_sweep));
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op,
                         input logic [IW-1:0] idx, input logic [DW-1:0] d);
    req_valid[r]        = v;
    req_op[2*r +: 2]    = op;
    req_idx[IW*r +: IW] = idx;
    req_data[DW*r +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_op    = '0;
    req_idx   = '0;
    req_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    sweep_req = 1'b0;
    clear_reqs();
    for (int r = 0; r < NQ; r++) set_req(r, 1'b1, 2'd2, 3'(r), 8'(r + 8'h10));
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    step();

    // LOAD 0x5A to reg1 from req0 with every requester valid
    rst = 1'b1;
    set_req(0, 1'b1, 2'd2, 3'd1, 8'h5A);
    for (int r = 1; r < NQ; r++) set_req(r, 1'b1, 2'd3, 3'd0, 8'h00);
    #1 chk("r033_ready", 64'(req_ready), 64'h1);
    step();
    chk("r033_ctrl", 64'(reg_ctrl), 64'h08);
    chk("r033_data", 64'(reg_data), 64'h5A);

    // rotate through all four requesters from a reset pointer
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int r = 0; r < NQ; r++) set_req(r, 1'b1, 2'd2, 3'(r), 8'(8'hA0 + r));
    for (int k = 0; k < NQ; k++) begin
      #1 chk("r034_grant", 64'(req_ready), 64'(1 << k));
      step();
      chk("r034_data", 64'(reg_data), 64'(8'hA0 + k));
    end

    // out-of-range index: transfer accepted, no ctrl, single idx_err pulse
    clear_reqs();
    set_req(2, 1'b1, 2'd3, 3'd7, 8'h11);
    #1 chk("r035_ready", 64'(req_ready), 64'h4);
    step();
    chk("r035_ctrl", 64'(reg_ctrl), 64'h0);
    chk("r035_err", 64'(idx_err), 64'h1);
    clear_reqs();
    step();
    chk("r035_err_pulse", 64'(idx_err), 64'h0);

`ifdef REG_BANK_ARB_SWEEP_EN
    set_req(1, 1'b1, 2'd2, 3'd2, 8'hAA);
    sweep_req = 1'b1;
    #1 chk("r036_ready_blocked", 64'(req_ready), 64'h0);
    step();
    for (int k = 0; k < NR; k++) begin
      if (k == NR - 1) sweep_req = 1'b0;
      #1 chk("r036_busy", 64'(sweep_busy), 64'h1);
      chk("r036_ready", 64'(req_ready), 64'h0);
      step();
      chk("r036_clr", 64'(reg_ctrl), 64'(1 << (2*k)));
    end
    #1 chk("r036_busy_done", 64'(sweep_busy), 64'h0);
    chk("r036_grant", 64'(req_ready), 64'h2);
    step();

    // reset in the second sweep cycle aborts the sweep
    clear_reqs();
    sweep_req = 1'b1;
    step();
    sweep_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("r037_ctrl", 64'(reg_ctrl), 64'h0);
    chk("r037_busy", 64'(sweep_busy), 64'h0);
    for (int r = 0; r < NQ; r++) set_req(r, 1'b1, 2'd0, 3'd0, 8'h00);
    #1 chk("r037_rr_ptr", 64'(req_ready), 64'h1);
    step();
`else
    clear_reqs();
    set_req(3, 1'b1, 2'd2, 3'd0, 8'h33);
    sweep_req = 1'b1;
    #1 chk("r038_grant", 64'(req_ready), 64'h8);
    step();
    chk("r038_busy", 64'(sweep_busy), 64'h0);
    chk("r038_ctrl", 64'(reg_ctrl), 64'h02);
    step();
    chk("r038_busy_held", 64'(sweep_busy), 64'h0);
`endif

    // randomized traffic with occasional sweeps and resets
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) != 0);
      sweep_req = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < NQ; r++) begin
        set_req(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), 8'($urandom));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of register data.
REQ-002 SHALL have parameter NUM_REGS, default 4, registers in bank (2..16); IDX_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_REQ, default 4, requesters (2..8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_op  input  2*NUM_REQ  per-requester op: 0 NONE, 1 CLR, 2 LOAD, 3 INCR.
REQ-008 SHALL have port req_idx  input  IDX_W*NUM_REQ  per-requester target register index.
REQ-009 SHALL have port req_data  input  DATA_WIDTH*NUM_REQ  per-requester LOAD data.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer = valid & ready.
REQ-011 SHALL have port reg_ctrl  output  2*NUM_REGS  per-register ctrl code, same encoding as req_op.
REQ-012 SHALL have port reg_data  output  DATA_WIDTH  broadcast LOAD data to bank.
REQ-013 SHALL have port sweep_req  input  1  request to clear whole bank.
REQ-014 SHALL have port sweep_busy  output  1  sweep in progress.
REQ-015 SHALL have port idx_err  output  1  one-cycle pulse on out-of-range index.

Function
REQ-016 SHALL implement FSM states IDLE and SWEEP; IDLE->SWEEP when sweep_req=1 in IDLE; SWEEP->IDLE after last clear issued.
REQ-017 SHALL in IDLE assert req_ready combinationally for the highest-priority requester with req_valid=1, round-robin order starting at pointer rr_ptr.
REQ-018 SHALL advance rr_ptr to (granted+1) mod NUM_REQ after each transfer; rr_ptr unchanged when no transfer.
REQ-019 SHALL drive, in cycle after transfer, reg_ctrl[idx] = accepted op and reg_data = accepted data for exactly one cycle; all other reg_ctrl fields 0.
REQ-020 SHALL hold reg_ctrl all-zero and reg_data at last value in cycles without issued op.
REQ-021 SHALL accept op NONE as a transfer (advances rr_ptr) but issue no ctrl.
REQ-022 SHALL accept idx >= NUM_REGS, issue no ctrl, pulse idx_err in following cycle.
REQ-023 SHALL sustain one transfer per cycle in IDLE (throughput 1, latency 1).
REQ-024 SHALL give sweep_req priority over pending requests in same cycle: req_ready all 0 that cycle.
REQ-025 SHALL in SWEEP hold req_ready=0, sweep_busy=1, issue CLR to register k in k-th SWEEP cycle, k=0..NUM_REGS-1, one register per cycle.
REQ-026 SHALL ignore sweep_req while in SWEEP (no restart, no queueing).
REQ-027 SHALL return to IDLE after NUM_REGS SWEEP cycles; rr_ptr preserved across sweep.

Reset
REQ-028 SHALL on rst=0 at rising edge: state IDLE, rr_ptr 0, reg_ctrl 0, reg_data 0, idx_err 0, sweep_busy 0.
REQ-029 SHALL abort in-flight sweep or pending issue on reset; no further ctrl emitted.
REQ-030 SHALL hold req_ready 0 while rst=0.

Configuration
REQ-031 SHALL compile SWEEP state only when REG_BANK_ARB_SWEEP_EN defined.
REQ-032 SHALL, without REG_BANK_ARB_SWEEP_EN, ignore sweep_req, tie sweep_busy 0, remain in IDLE permanently.

Verification
REQ-033 SHALL cover: NUM_REQ=4, all valid, op LOAD idx 1 data 0x5A from req0 after reset -> req_ready=0001, next cycle reg_ctrl[1]=2, reg_data=0x5A.
REQ-034 SHALL cover: all 4 valid held 4 cycles, rr_ptr=0 -> grants 0001,0010,0100,1000 in order, one per cycle.
REQ-035 SHALL cover: req2 INCR idx 7 with NUM_REGS=4 -> transfer, reg_ctrl all 0, idx_err=1 one cycle.
REQ-036 SHALL cover: sweep_req=1 with req1 valid (SWEEP_EN) -> req_ready 0, reg_ctrl[0..3]=1 on 4 consecutive cycles, sweep_busy 4 cycles, then req1 granted.
REQ-037 SHALL cover: rst=0 in second SWEEP cycle -> next cycle reg_ctrl 0, sweep_busy 0, rr_ptr 0.
REQ-038 SHALL cover: SWEEP_EN undefined, sweep_req=1 with req3 valid -> req3 granted same cycle, sweep_busy stays 0.
